// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffer frame sequencer (clear, draw, wait for vblank, swap front/back).
// Build option: define FB_CLEAR_EN to include the background-clear pass before each draw.
module fb_swap_ctrl #(
    parameter int W_FB   = 320,
    parameter int H_FB   = 240,
    parameter int ADDR_W = 17
) (
    input  logic              pix_clk,
    input  logic              prst_n,
    input  logic              enable,
    input  logic              vblank_start,
    input  logic [15:0]       bg_color,
    input  logic              rnd_we,
    input  logic [ADDR_W-1:0] rnd_addr,
    input  logic [15:0]       rnd_data,
    input  logic              rnd_done,
    output logic              rnd_ready,
    output logic              rnd_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_bank,
    output logic              front_sel,
    output logic              swap_pulse,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        overrun_cnt
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(W_FB * H_FB - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, DRAW, WAIT_VBL, SWAP} state_t;

`ifdef FB_CLEAR_EN
    localparam state_t FILL = CLEAR;
`else
    localparam state_t FILL = DRAW;
`endif

    state_t            state, state_nx;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [15:0]       wr_data_d;
    logic              overrun;

    // State register; reset aborts any frame in progress.
    always_ff @(posedge pix_clk or negedge prst_n) begin
        if (!prst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state; the clear pass ends on the last pixel address, not on counter wrap.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (enable) state_nx = FILL;
            CLEAR:    if (wr_addr == LAST) state_nx = DRAW;
            DRAW:     if (rnd_done) state_nx = vblank_start ? SWAP : WAIT_VBL;
            WAIT_VBL: if (vblank_start) state_nx = SWAP;
            SWAP:     state_nx = enable ? FILL : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Write-port source: clear sweep while clearing, renderer (range-checked) while drawing.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        overrun   = vblank_start && (state == CLEAR || state == DRAW) && state_nx != SWAP;
        if (state_nx == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = (state == CLEAR) ? wr_addr + 1'b1 : '0;
            wr_data_d = bg_color;
        end else if (state == DRAW && rnd_we) begin
            wr_en_d   = rnd_addr <= LAST;
            wr_addr_d = rnd_addr;
            wr_data_d = rnd_data;
        end
    end

    // Output registers; everything is aligned with the state it belongs to.
    always_ff @(posedge pix_clk or negedge prst_n) begin
        if (!prst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rnd_ready   <= 1'b0;
            rnd_start   <= 1'b0;
            swap_pulse  <= 1'b0;
            front_sel   <= 1'b0;
            wr_bank     <= 1'b1;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            rnd_ready  <= state_nx == DRAW;
            rnd_start  <= state_nx == DRAW && state != DRAW;
            swap_pulse <= state_nx == SWAP;
            if (state_nx == SWAP) begin
                front_sel <= ~front_sel;
                wr_bank   <= front_sel;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: scenario tests for fb_swap_ctrl on a 4x2 frame buffer with a write scoreboard.
module tb_fb_swap_ctrl;
    logic        clk = 1'b0;
    logic        prst_n = 1'b0;
    logic        enable = 1'b0;
    logic        vblank_start = 1'b0;
    logic [15:0] bg_color = '0;
    logic        rnd_we = 1'b0;
    logic [3:0]  rnd_addr = '0;
    logic [15:0] rnd_data = '0;
    logic        rnd_done = 1'b0;
    logic        rnd_ready, rnd_start, wr_en, wr_bank, front_sel, swap_pulse;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data, frame_cnt;
    logic [7:0]  overrun_cnt;

    int errors = 0;
    int checks = 0;
    int exp_ovr = 0;
    logic [19:0] sb[$];
    logic [19:0] mon_exp;

    fb_swap_ctrl #(.W_FB(4), .H_FB(2), .ADDR_W(4)) dut (
        .pix_clk(clk), .prst_n(prst_n), .enable(enable), .vblank_start(vblank_start),
        .bg_color(bg_color), .rnd_we(rnd_we), .rnd_addr(rnd_addr), .rnd_data(rnd_data),
        .rnd_done(rnd_done), .rnd_ready(rnd_ready), .rnd_start(rnd_start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank), .front_sel(front_sel),
        .swap_pulse(swap_pulse), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Every committed write must match the oldest expected write and target the back bank.
    always @(negedge clk) begin
        if (prst_n && wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: addr=%0d data=%h, want no write", wr_addr, wr_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({wr_addr, wr_data} !== mon_exp || wr_bank !== ~front_sel) begin
                    errors++;
                    $display("FAIL wr_scoreboard: addr=%0d data=%h bank=%b, want addr=%0d data=%h bank=%b",
                             wr_addr, wr_data, wr_bank, mon_exp[19:16], mon_exp[15:0], ~front_sel);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic bank, input bit vbl);
`ifdef FB_CLEAR_EN
        for (int i = 0; i < 8; i++) sb.push_back({4'(i), bg_color});
        for (int i = 0; i < 8; i++) begin
            if (vbl && i == 3) vblank_start = 1'b1;
            step();
            vblank_start = 1'b0;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'(i) || wr_data !== bg_color || wr_bank !== bank || rnd_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear[%0d]: en=%b addr=%0d data=%h bank=%b ready=%b, want en=1 addr=%0d data=%h bank=%b ready=0",
                         i, wr_en, wr_addr, wr_data, wr_bank, rnd_ready, i, bg_color, bank);
            end
        end
        if (vbl) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
`endif
        step();
        checks++;
        if (rnd_start !== 1'b1 || rnd_ready !== 1'b1 || wr_en !== 1'b0 || wr_bank !== bank) begin
            errors++;
            $display("FAIL draw_entry: start=%b ready=%b en=%b bank=%b, want 1 1 0 %b", rnd_start, rnd_ready, wr_en, wr_bank, bank);
        end
        step();
        checks++;
        if (rnd_start !== 1'b0 || rnd_ready !== 1'b1 || overrun_cnt !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL draw_hold: start=%b ready=%b ovr=%0d, want 0 1 %0d", rnd_start, rnd_ready, overrun_cnt, exp_ovr);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            enable = 1'($urandom);
            vblank_start = 1'($urandom);
            bg_color = 16'($urandom);
            rnd_we = 1'($urandom);
            rnd_addr = 4'($urandom);
            rnd_data = 16'($urandom);
            rnd_done = 1'($urandom);
            step();
            checks++;
            if ({wr_en, wr_addr, wr_data, rnd_ready, rnd_start, swap_pulse, front_sel, wr_bank, frame_cnt, overrun_cnt} !==
                {1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0}) begin
                errors++;
                $display("FAIL reset[%0d]: en=%b addr=%0d data=%h ready=%b start=%b swap=%b front=%b bank=%b frames=%0d ovr=%0d, want all 0 except bank=1",
                         i, wr_en, wr_addr, wr_data, rnd_ready, rnd_start, swap_pulse, front_sel, wr_bank, frame_cnt, overrun_cnt);
            end
        end
        {enable, vblank_start, bg_color, rnd_we, rnd_addr, rnd_data, rnd_done} = '0;
        prst_n = 1'b1;
        step();
        checks++;
        if (wr_en !== 1'b0 || rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: en=%b ready=%b, want 0 0", wr_en, rnd_ready);
        end
    endtask

    task automatic test_clear();
        enable = 1'b1;
        bg_color = 16'h0F0F;
        fill(1'b1, 1'b0);
    endtask

    task automatic test_draw_swap();
        rnd_we = 1'b1; rnd_addr = 4'd3; rnd_data = 16'h0ABC;
        sb.push_back({4'd3, 16'h0ABC});
        step();
        rnd_we = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 16'h0ABC) begin
            errors++;
            $display("FAIL draw_write: en=%b addr=%0d data=%h, want 1 3 0abc", wr_en, wr_addr, wr_data);
        end
        rnd_done = 1'b1;
        step();
        rnd_done = 1'b0;
        checks++;
        if (rnd_ready !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL done_ready: ready=%b en=%b, want 0 0", rnd_ready, wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (front_sel !== 1'b0 || swap_pulse !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL wait_vbl[%0d]: front=%b swap=%b en=%b, want 0 0 0", i, front_sel, swap_pulse, wr_en);
            end
        end
        vblank_start = 1'b1;
        step();
        vblank_start = 1'b0;
        checks++;
        if (front_sel !== 1'b1 || swap_pulse !== 1'b1 || frame_cnt !== 16'd1 || wr_bank !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL swap: front=%b swap=%b frames=%0d bank=%b en=%b, want 1 1 1 0 0", front_sel, swap_pulse, frame_cnt, wr_bank, wr_en);
        end
    endtask

    task automatic test_out_of_range();
        fill(1'b0, 1'b1);
        rnd_we = 1'b1; rnd_addr = 4'd8; rnd_data = 16'h1234;
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_8: en=%b, want 0", wr_en);
        end
        rnd_addr = 4'd15;
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_15: en=%b, want 0", wr_en);
        end
        rnd_addr = 4'd7; rnd_data = 16'h5555;
        sb.push_back({4'd7, 16'h5555});
        step();
        rnd_we = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 16'h5555 || wr_bank !== 1'b0) begin
            errors++;
            $display("FAIL last_addr: en=%b addr=%0d data=%h bank=%b, want 1 7 5555 0", wr_en, wr_addr, wr_data, wr_bank);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 2; i++) begin
            vblank_start = 1'b1;
            step();
            vblank_start = 1'b0;
            exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
            checks++;
            if (front_sel !== 1'b1 || swap_pulse !== 1'b0 || rnd_ready !== 1'b1 || overrun_cnt !== 8'(exp_ovr)) begin
                errors++;
                $display("FAIL overrun[%0d]: front=%b swap=%b ready=%b ovr=%0d, want 1 0 1 %0d", i, front_sel, swap_pulse, rnd_ready, overrun_cnt, exp_ovr);
            end
            step();
        end
    endtask

    task automatic test_done_vblank();
        enable = 1'b0;
        rnd_we = 1'b1; rnd_addr = 4'd5; rnd_data = 16'h0DEF;
        sb.push_back({4'd5, 16'h0DEF});
        rnd_done = 1'b1; vblank_start = 1'b1;
        step();
        {rnd_we, rnd_done, vblank_start} = '0;
        checks++;
        if (swap_pulse !== 1'b1 || front_sel !== 1'b0 || frame_cnt !== 16'd2 || wr_en !== 1'b1 || wr_addr !== 4'd5 || overrun_cnt !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL done_vbl_swap: swap=%b front=%b frames=%0d en=%b addr=%0d ovr=%0d, want 1 0 2 1 5 %0d",
                     swap_pulse, front_sel, frame_cnt, wr_en, wr_addr, overrun_cnt, exp_ovr);
        end
        step();
        checks++;
        if (wr_en !== 1'b0 || rnd_ready !== 1'b0 || swap_pulse !== 1'b0 || rnd_start !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: en=%b ready=%b swap=%b start=%b, want 0 0 0 0", wr_en, rnd_ready, swap_pulse, rnd_start);
        end
        rnd_we = 1'b1; rnd_addr = 4'd2; rnd_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (wr_en !== 1'b0 || rnd_ready !== 1'b0 || front_sel !== 1'b0 || frame_cnt !== 16'd2) begin
                errors++;
                $display("FAIL idle_ignore[%0d]: en=%b ready=%b front=%b frames=%0d, want 0 0 0 2", i, wr_en, rnd_ready, front_sel, frame_cnt);
            end
        end
        {rnd_we, rnd_done} = '0;
    endtask

    task automatic test_saturate();
        enable = 1'b1;
        bg_color = 16'h0123;
        fill(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            vblank_start = 1'b1;
            step();
            vblank_start = 1'b0;
            step();
        end
        checks++;
        if (overrun_cnt !== 8'd255 || front_sel !== 1'b0 || frame_cnt !== 16'd2 || rnd_ready !== 1'b1) begin
            errors++;
            $display("FAIL saturate: ovr=%0d front=%b frames=%0d ready=%b, want 255 0 2 1", overrun_cnt, front_sel, frame_cnt, rnd_ready);
        end
    endtask

    task automatic test_reset_midop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes outstanding, want 0", sb.size());
        end
        prst_n = 1'b0;
        #1;
        checks++;
        if (front_sel !== 1'b0 || wr_bank !== 1'b1 || frame_cnt !== 16'd0 || overrun_cnt !== 8'd0 || rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: front=%b bank=%b frames=%0d ovr=%0d ready=%b, want 0 1 0 0 0", front_sel, wr_bank, frame_cnt, overrun_cnt, rnd_ready);
        end
        enable = 1'b0;
        step();
        prst_n = 1'b1;
        step();
        checks++;
        if (wr_en !== 1'b0 || rnd_ready !== 1'b0 || rnd_start !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: en=%b ready=%b start=%b, want 0 0 0", wr_en, rnd_ready, rnd_start);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_draw_swap();
        test_out_of_range();
        test_overrun();
        test_done_vblank();
        test_saturate();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
